kulisch_to_fp16_drain: RTL and testbench
========================================

// Module: kulisch_to_fp16_drain
// PURPOSE
//  Drains one 4x4 tile of Kulisch accumulators produced by tensor_core_top (C_out).
//  Converts each element to IEEE-754 FP16 with round-to-nearest-even (RNE).
//  Captures the tile on a valid/ready handshake and converts one element per cycle
//  through a 2-stage pipeline. Presents the FP16 tile with out_valid/out_ready.
//  Sits between the Kulisch accumulator array and FP16 write-back.
// PARAMETERS
//  DWIDTH  16  output float width (FP16; only 16 supported)
//  AWIDTH  91  accumulator width; signed two's complement, value = C * 2^-48 (bit 48 = 1.0)
// PORTS
//  clk        in   1               clock
//  rst_n      in   1               reset, asynchronous, active-high
//  C_in       in   [0:3][0:3][91]  Kulisch tile to convert
//  in_valid   in   1               C_in valid
//  in_ready   out  1               block can accept a tile (high only in IDLE)
//  D_out      out  [0:3][0:3][16]  FP16 result tile
//  out_valid  out  1               D_out complete and stable
//  out_ready  in   1               consumer accepts D_out
//  flags      out  2               {ovf, inexact}: OR over all 16 elements of the current tile
// BEHAVIOUR
//  Reset (async, rst_n=1):
//   - state=IDLE; D_out, flags, out_valid and pipeline regs = 0; in_ready = 1 after release.
//   - Reset mid-tile discards all partial results.
//  FSM:
//   - IDLE -> CONV when in_valid && in_ready; C_in latched into tile reg, flags cleared, idx=0.
//   - CONV: idx 0..15 feeds stage1 in row-major order ([r][c], idx=4r+c).
//     -> DONE when element 15 is written by stage2.
//   - DONE: out_valid=1; D_out/flags held. -> IDLE when out_ready is sampled high.
//  in_ready=0 in CONV/DONE; tiles never overlap. in_valid is ignored outside IDLE.
//  Timing:
//   - Handshake at edge E0. Stage1 registers element k at E(1+k); stage2 writes it at E(2+k).
//   - out_valid is high after E17 (17 cycles from handshake edge).
//   - With out_ready tied high: out_valid is high 1 cycle; in_ready returns the cycle after.
//  Stage1 (per element):
//   - sign = bit 90; mag = |C|; -2^90 gives mag = 2^90, bit 90 set.
//   - p = index of leading one of mag (0..90); zero flag if mag==0. Register sign, mag, p, zero.
//  Stage2 (per element): e = p-48.
//   - zero -> 0x0000 (always +0, never -0).
//   - e > 15 -> sign|0x7C00, set ovf.
//   - -14 <= e <= 15:
//     - mant = mag[p-1:p-10]; guard = mag[p-11]; sticky = |mag[p-12:0] (missing bits = 0).
//     - exp field = e+15.
//   - e < -14 (subnormal / underflow):
//     - exp field = 0; mant = mag[33:24] (LSB weight 2^-24).
//     - guard = mag[23]; sticky = |mag[22:0].
//   - RNE: increment when guard && (sticky || mant[0]).
//     - Mantissa carry increments exp; subnormal carry becomes the min normal.
//     - exp field reaching 31 -> Inf, set ovf.
//   - inexact |= guard|sticky; an ovf element also sets inexact.
//  No NaN is ever produced. Results below 2^-25 round to signed zero.
//  Exception: a result that rounds to zero from an exact tie carries the input sign.
// TESTING
//  1. C[0][0]=2^48 (1.0), C[1][2]=-(5<<47) (-2.5), others 0.
//     -> D[0][0]=0x3C00, D[1][2]=0xC100, others 0x0000; flags=00; out_valid 17 cycles after handshake.
//  2. RNE ties:
//     - 2^48+2^37 -> 0x3C00, inexact=1.
//     - 2^48+3*2^37 -> 0x3C02.
//     - 2^48+2^37+1 -> 0x3C01.
//  3. Overflow:
//     - 65504*2^48 -> 0x7BFF, ovf=0.
//     - 65520*2^48 -> 0x7C00, ovf=1.
//     - 2^64 -> 0x7C00.
//     - -2^90 -> 0xFC00, ovf=1.
//  4. Subnormal:
//     - 2^24 (2^-24) -> 0x0001.
//     - 2^23 (tie) -> 0x0000, inexact=1.
//     - 3*2^23 -> 0x0002.
//     - 2^34-1 -> 0x0400 (min normal).
//  5. Backpressure: out_ready=0 for 10 cycles.
//     -> out_valid/D_out stable, in_ready=0, new in_valid ignored.
//     -> out_ready=1 -> IDLE, next tile accepted with flags cleared.
//  6. Assert rst_n at CONV idx=7.
//     -> out_valid=0, D_out=0, in_ready=1 after release; next full tile converts correctly.

Source files
------------

// File: rtl/kulisch_to_fp16_drain_if.sv
// Bundles the tile handshake between the Kulisch accumulator array, the
// drain/convert block and the FP16 write-back.
//   C_in      : Kulisch tile, [row][col], signed, value = C * 2^-48
//   in_valid  : C_in valid (producer -> drain)
//   in_ready  : drain can take a tile (drain -> producer)
//   D_out     : FP16 result tile, [row][col]
//   out_valid : D_out complete and stable (drain -> consumer)
//   out_ready : consumer accepts D_out (consumer -> drain)
//   flags     : {ovf, inexact} for the tile currently held
// master = the environment (producer + consumer), slave = the drain block.
interface kulisch_to_fp16_drain_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 91
);
  logic [0:3][0:3][AWIDTH-1:0] C_in;
  logic                        in_valid;
  logic                        in_ready;
  logic [0:3][0:3][DWIDTH-1:0] D_out;
  logic                        out_valid;
  logic                        out_ready;
  logic [1:0]                  flags;

  modport master (
    output C_in, in_valid, out_ready,
    input  in_ready, D_out, out_valid, flags
  );

  modport slave (
    input  C_in, in_valid, out_ready,
    output in_ready, D_out, out_valid, flags
  );
endinterface

// File: rtl/kulisch_to_fp16_drain.sv
// Drains one 4x4 tile of Kulisch accumulators and converts every element to
// IEEE-754 FP16 with round-to-nearest-even, one element per clock through a
// two-stage pipeline (stage1: sign/magnitude + leading-one position,
// stage2: field extraction, rounding, packing).
// Ports:
//   clk   : clock
//   rst_n : asynchronous reset, ACTIVE HIGH (historic name kept)
//   bus   : kulisch_to_fp16_drain_if.slave -- C_in/in_valid/in_ready tile
//           input, D_out/out_valid/out_ready tile output, flags {ovf, inexact}
// Only DWIDTH = 16 and AWIDTH = 91 (binary point above bit 48) are supported.
module kulisch_to_fp16_drain #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 91
) (
  input  logic                    clk,
  input  logic                    rst_n,
  kulisch_to_fp16_drain_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t state_reg, state_next;

  logic [0:3][0:3][AWIDTH-1:0] tile_reg;
  logic [4:0]                  idx_reg;     // next element to feed; bit 4 = all fed
  logic                        ovf_reg;
  logic                        inexact_reg;

  // stage1 registers
  logic        s1_valid_reg;
  logic [3:0]  s1_idx_reg;
  logic        s1_sign_reg;
  logic        s1_zero_reg;
  logic [6:0]  s1_p_reg;
  // Bits above 62 are never needed: p > 63 always overflows, and for p = 63
  // the leading one itself is implicit.
  logic [62:0] s1_mag_reg;

  logic accept;
  logic feed;
  logic in_ready_c;
  logic out_valid_c;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    feed        = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        feed = ~idx_reg[4];
        if (s1_valid_reg && (s1_idx_reg == 4'd15)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- stage1
  logic [AWIDTH-1:0] elem;
  logic              elem_sign;
  logic [AWIDTH-1:0] elem_mag;
  logic [6:0]        elem_p;
  logic              elem_zero;

  always_comb begin
    elem      = tile_reg[idx_reg[3:2]][idx_reg[1:0]];
    elem_sign = elem[AWIDTH-1];
    // Most negative value negates to itself, which read unsigned is 2^90.
    elem_mag  = elem_sign ? AWIDTH'(~elem + 1'b1) : elem;
    elem_zero = (elem_mag == '0);
    elem_p    = '0;
    for (int i = 0; i < AWIDTH; i++) begin
      if (elem_mag[i]) begin
        elem_p = 7'(i);
      end
    end
  end

  // ---------------------------------------------------------------- stage2
  logic [5:0]  norm_sh;
  logic [62:0] norm;
  logic        in_norm;
  logic        in_ovf;
  logic [4:0]  exp_field;
  logic [9:0]  mant;
  logic        guard;
  logic        sticky;
  logic        rnd_inc;
  logic [14:0] rounded;
  logic [15:0] res_word;
  logic        res_ovf;
  logic        res_inexact;

  always_comb begin
    // Left-justify so the bit just below the leading one lands at bit 62.
    norm_sh   = 6'd63 - s1_p_reg[5:0];
    norm      = s1_mag_reg << norm_sh;
    in_ovf    = (s1_p_reg > 7'd63);   // e = p - 48 > 15
    in_norm   = (s1_p_reg >= 7'd34);  // e >= -14
    if (in_norm) begin
      exp_field = 5'(s1_p_reg - 7'd33);
      mant      = norm[62:53];
      guard     = norm[52];
      sticky    = |norm[51:0];
    end else begin
      // Subnormal grid is fixed: LSB weight 2^-24 = bit 24.
      exp_field = 5'd0;
      mant      = s1_mag_reg[33:24];
      guard     = s1_mag_reg[23];
      sticky    = |s1_mag_reg[22:0];
    end
    rnd_inc = guard & (sticky | mant[0]);
    // Mantissa carry ripples into the exponent field: subnormal 0x3FF rolls to
    // the min normal, exponent 30 all-ones rolls to 31 = Inf with zero mantissa.
    rounded = {exp_field, mant} + 15'(rnd_inc);

    res_word    = '0;
    res_ovf     = 1'b0;
    res_inexact = 1'b0;
    if (s1_zero_reg) begin
      res_word = 16'h0000;
    end else if (in_ovf) begin
      res_word    = {s1_sign_reg, 15'h7C00};
      res_ovf     = 1'b1;
      res_inexact = 1'b1;
    end else begin
      res_word    = {s1_sign_reg, rounded};
      res_ovf     = (rounded[14:10] == 5'h1F);
      res_inexact = guard | sticky | res_ovf;
    end
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg    <= IDLE;
      tile_reg     <= '0;
      idx_reg      <= '0;
      ovf_reg      <= 1'b0;
      inexact_reg  <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_idx_reg   <= '0;
      s1_sign_reg  <= 1'b0;
      s1_zero_reg  <= 1'b0;
      s1_p_reg     <= '0;
      s1_mag_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      s1_valid_reg <= feed;
      if (accept) begin
        tile_reg    <= bus.C_in;
        idx_reg     <= '0;
        ovf_reg     <= 1'b0;
        inexact_reg <= 1'b0;
      end else if (feed) begin
        idx_reg <= idx_reg + 5'd1;
      end
      if (feed) begin
        s1_idx_reg  <= idx_reg[3:0];
        s1_sign_reg <= elem_sign;
        s1_zero_reg <= elem_zero;
        s1_p_reg    <= elem_p;
        s1_mag_reg  <= elem_mag[62:0];
      end
      if (s1_valid_reg) begin
        ovf_reg     <= ovf_reg | res_ovf;
        inexact_reg <= inexact_reg | res_inexact;
      end
    end
  end

  // One result register per tile element, written when stage2 retires it.
  logic [0:3][0:3][DWIDTH-1:0] d_out_c;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_elem
      logic [DWIDTH-1:0] elem_reg;
      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
          elem_reg <= '0;
        end else if (s1_valid_reg && (s1_idx_reg == 4'(gi))) begin
          elem_reg <= res_word;
        end
      end
      assign d_out_c[gi/4][gi%4] = elem_reg;
    end
  endgenerate

  assign bus.D_out     = d_out_c;
  assign bus.flags     = {ovf_reg, inexact_reg};
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;

endmodule

// File: tb/tb_kulisch_to_fp16_drain.sv
// Scoreboard bench: tiles are pushed with their expected FP16 results when
// the input handshake happens; a monitor compares whenever a tile is taken.
module tb_kulisch_to_fp16_drain;

  localparam int P   = 10;
  localparam int LAT = 17;

  typedef logic [90:0] acc_t;
  typedef logic [15:0][90:0] tile_t;
  typedef struct packed {
    logic [15:0][15:0] d;
    logic [1:0]        fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #(P/2) clk = ~clk;

  kulisch_to_fp16_drain_if #(.DWIDTH(16), .AWIDTH(91)) bus ();

  kulisch_to_fp16_drain #(.DWIDTH(16), .AWIDTH(91)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  exp_t exp_q[$];
  longint hs_q[$];

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h required %h", nm, got, want);
  endfunction

  // Reference: quantum = 2^(p-10) in the normal range, 2^-24 below it;
  // divide, round half to even on the remainder, then encode.
  function automatic void ref_conv(input acc_t c, output logic [15:0] r,
                                   output logic ovf, output logic inx);
    acc_t neg;
    logic [127:0] m, q, rem, half;
    int p, sh, ex;
    logic sgn;
    sgn = c[90];
    neg = sgn ? -c : c;
    m   = 128'(neg);
    r = 16'h0; ovf = 1'b0; inx = 1'b0;
    if (m == 0) return;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    sh   = (p >= 34) ? p - 10 : 24;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = 128'(1) << (sh - 1);
    inx  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (p >= 34) begin
      if (q == 2048) begin q = 1024; p++; end
      ex = p - 33;
      if (ex >= 31) begin r = 16'h7C00; ovf = 1'b1; inx = 1'b1; end
      else r = 16'(ex * 1024 + int'(q) - 1024);
    end else begin
      r = 16'(q);
    end
    if (sgn) r = r | 16'h8000;
  endfunction

  function automatic exp_t ref_tile(input tile_t t);
    exp_t e;
    logic [15:0] r;
    logic o, x;
    e = '0;
    for (int k = 0; k < 16; k++) begin
      ref_conv(t[k], r, o, x);
      e.d[k] = r;
      e.fl   = e.fl | {o, x};
    end
    return e;
  endfunction

  function automatic acc_t pw(input int n);
    return acc_t'(1) << n;
  endfunction

  function automatic acc_t rand_elem();
    logic [127:0] rnd;
    int w, sh, cat;
    acc_t v;
    rnd = {$urandom, $urandom, $urandom, $urandom};
    cat = $urandom_range(0, 5);
    case (cat)
      0: v = '0;
      1: begin w = $urandom_range(1, 91); v = 91'(rnd >> (128 - w)); end
      2: begin
        sh = $urandom_range(24, 62);
        v  = (acc_t'($urandom_range(1, 2047)) << sh) | (acc_t'(1) << (sh - 1));
      end
      3: begin w = $urandom_range(35, 66); v = 91'(rnd >> (128 - w)); end
      4: begin w = $urandom_range(1, 34); v = 91'(rnd >> (128 - w)); end
      default: v = rnd[90:0];
    endcase
    if (cat != 0 && $urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int k = 0; k < 16; k++) t[k] = rand_elem();
    return t;
  endfunction

  // ---------------------------------------------------------------- monitor
  logic prev_valid = 1'b0;
  int   tile_no = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (bus.out_valid && !prev_valid) begin
      if (hs_q.size() == 0) chk("unexpected out_valid", 32'd1, 32'd0);
      else chk($sformatf("tile%0d latency(time)", tile_no),
               32'($time - hs_q[0]), 32'(LAT * P + P / 2));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected tile", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        void'(hs_q.pop_front());
        for (int k = 0; k < 16; k++)
          chk($sformatf("tile%0d D[%0d][%0d]", tile_no, k / 4, k % 4),
              32'(bus.D_out[k / 4][k % 4]), 32'(mon_e.d[k]));
        chk($sformatf("tile%0d flags", tile_no), 32'(bus.flags), 32'(mon_e.fl));
        tile_no++;
      end
    end
    prev_valid = bus.out_valid;
  end

  // ---------------------------------------------------------------- stimulus
  task automatic send_tile(input tile_t t, input exp_t e);
    int n;
    n = 0;
    @(posedge clk); #2;
    for (int k = 0; k < 16; k++) bus.C_in[k / 4][k % 4] = t[k];
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      chk("in_ready timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(e);
    hs_q.push_back(longint'($time));
    #2;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 16; k++) bus.C_in[k / 4][k % 4] = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) chk("drain timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  tile_t t1, t2, t3, t4, t;
  exp_t  e1, e2, e3, e4, e;
  logic [0:3][0:3][15:0] snap;

  initial begin
    bus.C_in      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset D_out zero", 32'(bus.D_out != '0), 32'd0);
    chk("reset flags", 32'(bus.flags), 32'd0);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", 32'(bus.in_ready), 32'd1);

    // Basic values.
    t1 = '0; e1 = '0;
    t1[0] = pw(48);              e1.d[0] = 16'h3C00;
    t1[6] = -(acc_t'(5) << 47);  e1.d[6] = 16'hC100;
    send_tile(t1, e1);
    wait_empty();

    // Ties, max finite, subnormals.
    t2 = '0; e2 = '0; e2.fl = 2'b01;
    t2[0] = pw(48) + pw(37);               e2.d[0] = 16'h3C00;
    t2[1] = pw(48) + 3 * pw(37);           e2.d[1] = 16'h3C02;
    t2[2] = pw(48) + pw(37) + 1;           e2.d[2] = 16'h3C01;
    t2[3] = acc_t'(65504) << 48;           e2.d[3] = 16'h7BFF;
    t2[4] = pw(23);                        e2.d[4] = 16'h0000;
    t2[5] = pw(24);                        e2.d[5] = 16'h0001;
    t2[6] = 3 * pw(23);                    e2.d[6] = 16'h0002;
    t2[7] = pw(34) - 1;                    e2.d[7] = 16'h0400;
    send_tile(t2, e2);
    wait_empty();

    // Overflow, and a negative tie that rounds to signed zero; held under backpressure.
    t3 = '0; e3 = '0; e3.fl = 2'b11;
    t3[0]  = acc_t'(65520) << 48;  e3.d[0]  = 16'h7C00;
    t3[5]  = pw(64);               e3.d[5]  = 16'h7C00;
    t3[10] = pw(90);               e3.d[10] = 16'hFC00;
    t3[15] = -pw(23);              e3.d[15] = 16'h8000;
    @(posedge clk); #2 bus.out_ready = 1'b0;
    send_tile(t3, e3);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
      chk("bp out_valid seen", 32'(bus.out_valid), 32'd1);
    end
    snap = bus.D_out;
    @(posedge clk); #2;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 16; k++) bus.C_in[k / 4][k % 4] = pw(48);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d D_out stable", i), 32'(bus.D_out == snap), 32'd1);
      chk($sformatf("bp%0d in_ready", i), 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #2;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_empty();

    // Exact tile right after: flags must be cleared.
    t4 = '0; e4 = '0;
    t4[9] = 3 * pw(48);  e4.d[9] = 16'h4200;
    send_tile(t4, e4);
    wait_empty();

    // Reset while element 7 is being fed.
    t = rand_tile();
    t[0] = pw(48);
    send_tile(t, ref_tile(t));
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b1;
    void'(exp_q.pop_back());
    void'(hs_q.pop_back());
    @(negedge clk);
    chk("midreset out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset D_out zero", 32'(bus.D_out != '0), 32'd0);
    chk("midreset flags", 32'(bus.flags), 32'd0);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midreset in_ready", 32'(bus.in_ready), 32'd1);
    t = rand_tile();
    send_tile(t, ref_tile(t));
    wait_empty();

    // Randomized tiles against the reference model.
    for (int n = 0; n < 40; n++) begin
      t = rand_tile();
      e = ref_tile(t);
      send_tile(t, e);
    end
    wait_empty();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
